// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle for the bit-serial adder controller.
// The ovf signal exists only when SERIAL_ADD_CTRL_OVF_EN is defined.
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             c_out;
`ifdef SERIAL_ADD_CTRL_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b, c_in,
        input  busy, done, result, c_out
`ifdef SERIAL_ADD_CTRL_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, a, b, c_in,
        output busy, done, result, c_out
`ifdef SERIAL_ADD_CTRL_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder bit per clock, LSB first, start/busy/done handshake.
// Optional two's-complement overflow output enabled by SERIAL_ADD_CTRL_OVF_EN.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_add_ctrl_if.slave  bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sha_q, sha_d;
    logic [WIDTH-1:0] shb_q, shb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
`ifdef SERIAL_ADD_CTRL_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic sum_bit;
    logic sum_carry;

    // Shared single-bit full adder.
    assign sum_bit   = sha_q[0] ^ shb_q[0] ^ carry_q;
    assign sum_carry = (sha_q[0] & shb_q[0]) | (carry_q & (sha_q[0] ^ shb_q[0]));

    always_comb begin
        state_d  = state_q;
        sha_d    = sha_q;
        shb_d    = shb_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        c_out_d  = c_out_q;
`ifdef SERIAL_ADD_CTRL_OVF_EN
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    sha_d   = bus.a;
                    shb_d   = bus.b;
                    carry_d = bus.c_in;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                result_d = {sum_bit, result_q[WIDTH-1:1]};
                sha_d    = sha_q >> 1;
                shb_d    = shb_q >> 1;
                carry_d  = sum_carry;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    c_out_d = sum_carry;
`ifdef SERIAL_ADD_CTRL_OVF_EN
                    // carry_q is the carry into the MSB on this last edge.
                    ovf_d   = carry_q ^ sum_carry;
`endif
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            sha_q    <= '0;
            shb_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            c_out_q  <= 1'b0;
`ifdef SERIAL_ADD_CTRL_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sha_q    <= sha_d;
            shb_q    <= shb_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            c_out_q  <= c_out_d;
`ifdef SERIAL_ADD_CTRL_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.busy   = (state_q != StIdle);
    assign bus.done   = (state_q == StDone);
    assign bus.result = result_q;
    assign bus.c_out  = c_out_q;
`ifdef SERIAL_ADD_CTRL_OVF_EN
    assign bus.ovf    = ovf_q;
`endif
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized and directed bench for serial_add_ctrl against an arithmetic reference model.
// Checks ovf as well when SERIAL_ADD_CTRL_OVF_EN is defined.
module tb_serial_add_ctrl;
    localparam int unsigned WIDTH = 8;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    serial_add_ctrl_if #(.WIDTH(WIDTH)) ifc ();

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pos = edges since the accepting edge, -1 when idle.
    int             pos;
    logic [WIDTH:0] m_sum;
    logic           m_ovf_pend;
    logic [WIDTH-1:0] m_res;
    logic           m_cout;
    logic           m_ovf;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            pos    = -1;
            m_res  = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
        end else if (pos < 0) begin
            if (ifc.start) begin
                pos        = 0;
                m_sum      = {1'b0, ifc.a} + {1'b0, ifc.b} + {{WIDTH{1'b0}}, ifc.c_in};
                m_ovf_pend = (ifc.a[WIDTH-1] == ifc.b[WIDTH-1]) &&
                             (m_sum[WIDTH-1] != ifc.a[WIDTH-1]);
            end
        end else begin
            pos++;
            if (pos == WIDTH) begin
                m_res  = m_sum[WIDTH-1:0];
                m_cout = m_sum[WIDTH];
                m_ovf  = m_ovf_pend;
            end else if (pos > WIDTH) begin
                pos = -1;
            end
        end
        #1;
        check_eq("busy", 64'(ifc.busy), 64'(pos >= 0));
        check_eq("done", 64'(ifc.done), 64'(pos == WIDTH));
        check_eq("c_out", 64'(ifc.c_out), 64'(m_cout));
`ifdef SERIAL_ADD_CTRL_OVF_EN
        check_eq("ovf", 64'(ifc.ovf), 64'(m_ovf));
`endif
        if (pos < 0 || pos == WIDTH) check_eq("result", 64'(ifc.result), 64'(m_res));
    endtask

    task automatic drive(input logic s, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic ci);
        @(negedge clk);
        ifc.start = s;
        ifc.a     = av;
        ifc.b     = bv;
        ifc.c_in  = ci;
    endtask

    // Single operation from idle; measures edges from acceptance until done.
    task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic ci);
        int n;
        drive(1'b1, av, bv, ci);
        tick();
        drive(1'b0, ~av, ~bv, ~ci);
        n = 0;
        while (!ifc.done && n < 20) begin
            tick();
            n++;
        end
        check_eq("latency", 64'(n), 64'(WIDTH));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        pos      = -1;
        m_sum    = '0;
        m_ovf_pend = 1'b0;
        m_res    = '0;
        m_cout   = 1'b0;
        m_ovf    = 1'b0;
        rst       = 1'b1;
        ifc.start = 1'b0;
        ifc.a     = '0;
        ifc.b     = '0;
        ifc.c_in  = 1'b0;
        tick();
        tick();
        check_eq("rst_result", 64'(ifc.result), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        do_op(8'h5A, 8'h33, 1'b0);
        check_eq("op1_result", 64'(ifc.result), 64'h8D);
        check_eq("op1_cout", 64'(ifc.c_out), 64'h0);
`ifdef SERIAL_ADD_CTRL_OVF_EN
        check_eq("op1_ovf", 64'(ifc.ovf), 64'h1);
`endif
        tick();
        do_op(8'hFF, 8'h01, 1'b0);
        check_eq("op2_result", 64'(ifc.result), 64'h00);
        check_eq("op2_cout", 64'(ifc.c_out), 64'h1);
        tick();
        do_op(8'hFF, 8'h00, 1'b1);
        check_eq("op3_result", 64'(ifc.result), 64'h00);
        check_eq("op3_cout", 64'(ifc.c_out), 64'h1);
        tick();

        // Start while busy is ignored.
        drive(1'b1, 8'h10, 8'h20, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        drive(1'b1, 8'hAA, 8'hAA, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < WIDTH + 4; i++) tick();
        check_eq("busy_ign_result", 64'(ifc.result), 64'h30);
        check_eq("busy_ign_cout", 64'(ifc.c_out), 64'h0);

        // Reset mid-operation.
        drive(1'b1, 8'h7F, 8'h7F, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_eq("abort_busy", 64'(ifc.busy), 64'h0);
        check_eq("abort_result", 64'(ifc.result), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        do_op(8'h7F, 8'h7F, 1'b0);
        check_eq("post_abort_result", 64'(ifc.result), 64'hFE);
        tick();

        // Reset and start together: reset wins.
        drive(1'b1, 8'h12, 8'h34, 1'b1);
        rst = 1'b1;
        tick();
        check_eq("rst_start_busy", 64'(ifc.busy), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_eq("start_after_rst", 64'(ifc.busy), 64'h1);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < WIDTH + 2; i++) tick();

        // Start held high with alternating operands.
        for (int i = 0; i < 5 * (WIDTH + 2); i++) begin
            if (i[0]) drive(1'b1, 8'hC3, 8'h5D, 1'b1);
            else      drive(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            tick();
        end

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) < 40), WIDTH'($urandom), WIDTH'($urandom),
                  1'($urandom));
            rst = ($urandom_range(0, 99) < 2);
            tick();
        end
        @(negedge clk);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
